// File: rtl/accum_reg_if.sv
// rtl/accum_reg_if.sv - accumulator operand/command and result bundle
interface accum_reg_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          En;
    logic          Sub;
    logic          Load;
    logic          Clear;
    logic [W-1:0]  D;
    logic [W-1:0]  Q;
    logic          Cout;
    logic          Ovf;
    logic          Valid;
    logic [CW-1:0] Count;

    // Driver side: issues commands and operands, observes results
    modport master (
        output En, Sub, Load, Clear, D,
        input  Q, Cout, Ovf, Valid, Count
    );

    // Accumulator side
    modport slave (
        input  En, Sub, Load, Clear, D,
        output Q, Cout, Ovf, Valid, Count
    );
endinterface

// File: rtl/accum_reg.sv
// rtl/accum_reg.sv - registered W-bit accumulator with carry/borrow, sticky overflow and op count (option: ACCUM_SATURATE_EN)
module accum_reg #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic        Clk,
    input  logic        R,
    accum_reg_if.slave  bus
);
    logic [W-1:0]  q_r;
    logic          cout_r;
    logic          ovf_r;
    logic          valid_r;
    logic [CW-1:0] count_r;

    logic [W:0]    sum_ext;
    logic [W-1:0]  diff;
    logic          borrow;
    logic [W-1:0]  add_q;
    logic [W-1:0]  sub_q;
    logic [CW-1:0] count_inc;

    // Arithmetic results and saturating counter increment for this cycle
    always_comb begin
        sum_ext   = {1'b0, q_r} + {1'b0, bus.D};
        diff      = q_r - bus.D;
        borrow    = (q_r < bus.D);
`ifdef ACCUM_SATURATE_EN
        add_q     = sum_ext[W] ? {W{1'b1}} : sum_ext[W-1:0];
        sub_q     = borrow ? {W{1'b0}} : diff;
`else
        add_q     = sum_ext[W-1:0];
        sub_q     = diff;
`endif
        count_inc = (&count_r) ? count_r : count_r + 1'b1;
    end

    // State update with priority Clear > Load > En > hold
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            q_r     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            count_r <= '0;
        end else if (bus.Clear) begin
            q_r     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b1;
            count_r <= '0;
        end else if (bus.Load) begin
            q_r     <= bus.D;
            cout_r  <= 1'b0;
            valid_r <= 1'b1;
            count_r <= count_inc;
        end else if (bus.En) begin
            if (bus.Sub) begin
                q_r    <= sub_q;
                cout_r <= borrow;
                ovf_r  <= ovf_r | borrow;
            end else begin
                q_r    <= add_q;
                cout_r <= sum_ext[W];
                ovf_r  <= ovf_r | sum_ext[W];
            end
            valid_r <= 1'b1;
            count_r <= count_inc;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign bus.Q     = q_r;
    assign bus.Cout  = cout_r;
    assign bus.Ovf   = ovf_r;
    assign bus.Valid = valid_r;
    assign bus.Count = count_r;
endmodule

// File: tb/tb_accum_reg.sv
// tb/tb_accum_reg.sv - directed vector bench for accum_reg (W=8, CW=4)
module tb_accum_reg;
    logic Clk;
    logic R;

    accum_reg_if #(.W(8), .CW(4)) bus ();

    accum_reg #(.W(8), .CW(4)) dut (
        .Clk (Clk),
        .R   (R),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       clear;
        logic       load;
        logic       en;
        logic       sub;
        logic [7:0] d;
        logic [7:0] q;
        logic       cout;
        logic       ovf;
        logic       valid;
        logic [3:0] cnt;
    } vec_t;

`ifdef ACCUM_SATURATE_EN
    localparam logic [7:0] Q_ADD_OVF  = 8'hFF;
    localparam logic [7:0] Q_ADD_NEXT = 8'hFF;
    localparam logic       C_ADD_NEXT = 1'b1;
    localparam logic [7:0] Q_SUB_UNF  = 8'h00;
`else
    localparam logic [7:0] Q_ADD_OVF  = 8'h10;
    localparam logic [7:0] Q_ADD_NEXT = 8'h11;
    localparam logic       C_ADD_NEXT = 1'b0;
    localparam logic [7:0] Q_SUB_UNF  = 8'hFE;
`endif

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] q, input logic c,
                           input logic o, input logic v, input logic [3:0] n);
        chk({tag, ".Q"},     {24'd0, bus.Q}, {24'd0, q});
        chk({tag, ".Cout"},  {31'd0, bus.Cout}, {31'd0, c});
        chk({tag, ".Ovf"},   {31'd0, bus.Ovf}, {31'd0, o});
        chk({tag, ".Valid"}, {31'd0, bus.Valid}, {31'd0, v});
        chk({tag, ".Count"}, {28'd0, bus.Count}, {28'd0, n});
    endtask

    task automatic drive(input logic clr, input logic ld, input logic en,
                         input logic sb, input logic [7:0] d);
        bus.Clear = clr;
        bus.Load  = ld;
        bus.En    = en;
        bus.Sub   = sb;
        bus.D     = d;
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        R = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        #2;
        chk_all("reset", 8'h00, 0, 0, 0, 4'd0);
        #10;
        R = 1'b1;
        @(posedge Clk);
        #1;

        //           clr ld en sb  d      q           cout        ovf v  cnt
        tbl.push_back('{1, 0, 0, 0, 8'h00, 8'h00,      0,          0, 1, 4'd0});
        tbl.push_back('{0, 1, 0, 0, 8'h3C, 8'h3C,      0,          0, 1, 4'd1});
        tbl.push_back('{0, 0, 1, 0, 8'h05, 8'h41,      0,          0, 1, 4'd2});
        tbl.push_back('{0, 0, 0, 1, 8'hFF, 8'h41,      0,          0, 0, 4'd2});
        tbl.push_back('{0, 1, 0, 0, 8'hF0, 8'hF0,      0,          0, 1, 4'd3});
        tbl.push_back('{0, 0, 1, 0, 8'h20, Q_ADD_OVF,  1,          1, 1, 4'd4});
        tbl.push_back('{0, 0, 1, 0, 8'h01, Q_ADD_NEXT, C_ADD_NEXT, 1, 1, 4'd5});
        tbl.push_back('{0, 1, 0, 0, 8'h05, 8'h05,      0,          1, 1, 4'd6});
        tbl.push_back('{0, 0, 1, 1, 8'h07, Q_SUB_UNF,  1,          1, 1, 4'd7});
        tbl.push_back('{0, 1, 0, 0, 8'h10, 8'h10,      0,          1, 1, 4'd8});
        tbl.push_back('{0, 0, 1, 1, 8'h01, 8'h0F,      0,          1, 1, 4'd9});
        tbl.push_back('{0, 1, 0, 0, 8'h77, 8'h77,      0,          1, 1, 4'd10});
        tbl.push_back('{0, 0, 1, 1, 8'h77, 8'h00,      0,          1, 1, 4'd11});
        tbl.push_back('{0, 1, 0, 0, 8'hFF, 8'hFF,      0,          1, 1, 4'd12});
        tbl.push_back('{0, 0, 1, 0, 8'h00, 8'hFF,      0,          1, 1, 4'd13});
        tbl.push_back('{0, 1, 0, 0, 8'h77, 8'h77,      0,          1, 1, 4'd14});
        tbl.push_back('{1, 1, 1, 0, 8'hAA, 8'h00,      0,          0, 1, 4'd0});
        tbl.push_back('{0, 0, 0, 0, 8'h55, 8'h00,      0,          0, 0, 4'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].clear, tbl[i].load, tbl[i].en, tbl[i].sub, tbl[i].d);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].cout, tbl[i].ovf,
                    tbl[i].valid, tbl[i].cnt);
        end

        // Asynchronous reset between edges with Q=5A, Ovf=1, Count=3
        drive(0, 1, 0, 0, 8'hF0); step();
        drive(0, 0, 1, 0, 8'h20); step();
        drive(0, 1, 0, 0, 8'h5A); step();
        chk_all("pre_rst", 8'h5A, 0, 1, 1, 4'd3);
        drive(0, 0, 1, 0, 8'h01);
        #2;
        R = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 0, 0, 0, 4'd0);
        step();
        step();
        chk_all("rst_held", 8'h00, 0, 0, 0, 4'd0);
        drive(0, 1, 0, 0, 8'h12);
        #2;
        R = 1'b1;
        step();
        chk_all("first_after_rst", 8'h12, 0, 0, 1, 4'd1);

        // Counter saturation over 20 back-to-back adds
        drive(1, 0, 0, 0, 8'h00); step();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 8'h01);
            step();
            chk_all($sformatf("sat%0d", i), 8'(i + 1), 0, 0, 1,
                    (i + 1 > 15) ? 4'd15 : 4'(i + 1));
        end
        drive(1, 0, 0, 0, 8'h00); step();
        chk_all("clr_cnt", 8'h00, 0, 0, 1, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accum_reg.md
Name: accum_reg

Overview:
Parametrised registered accumulator, the next generation of the 8-bit register-plus-adder datapath feeding the HEX displays.
- Holds a W-bit running value.
- Each enabled cycle it loads, adds or subtracts the D input.
- Reports per-operation carry/borrow, a sticky overflow flag and a saturating operation count.
- Q and Count drive the BCD_7seg digits; Ovf drives an LEDR.

Parameters:
W, 8, datapath width of D and Q (W >= 2)
CW, 4, width of the operation counter Count (CW >= 1)

Ports:
Clk  input  1  clock, rising-edge active
R  input  1  asynchronous active-low reset (R=0 resets)
En  input  1  perform add/subtract this cycle
Sub  input  1  0 = add D, 1 = subtract D (sampled only when En=1)
Load  input  1  load D into accumulator
Clear  input  1  synchronous clear of accumulator, flags and counter
D  input  W  operand
Q  output  W  accumulator value (registered)
Cout  output  1  carry (add) or borrow (sub) of the last accepted arithmetic op
Ovf  output  1  sticky overflow/underflow flag
Valid  output  1  pulses 1 the cycle after any accepted Clear/Load/En
Count  output  CW  number of accepted Load/En ops since last Clear/reset

Behaviour:
- Reset (R=0, asynchronous, any time including mid-operation):
  - Q=0, Cout=0, Ovf=0, Valid=0, Count=0 immediately.
  - Outputs stay at those values while R=0.
  - The first edge after R rises is a normal cycle.
- All other updates occur on the rising edge of Clk. Latency is 1 cycle: inputs sampled at edge n appear on Q/flags after edge n.
- Priority per cycle: Clear > Load > En > hold.
- Clear=1:
  - Q<=0, Cout<=0, Ovf<=0, Count<=0, Valid<=1.
  - Load, En and D are ignored.
- Load=1 (no Clear):
  - Q<=D, Cout<=0, Ovf unchanged, Count<=Count+1 (saturating), Valid<=1.
- En=1, Sub=0 (no Clear/Load):
  - Compute {c,s} = {1'b0,Q} + {1'b0,D} in W+1 bits.
  - Q<=s, Cout<=c, Ovf<=Ovf|c.
  - Count increments (saturating), Valid<=1.
- En=1, Sub=1:
  - Compute s = Q - D mod 2^W; borrow b = (Q < D), unsigned.
  - Q<=s, Cout<=b, Ovf<=Ovf|b.
  - Count increments (saturating), Valid<=1.
- Hold (no Clear/Load/En): Q, Cout, Ovf and Count unchanged; Valid<=0.
- Valid is never held high across an idle cycle. Back-to-back operations give a continuous Valid=1.
- Count saturates at 2^CW-1 and never wraps. Only Clear or reset returns it to 0.
- Ovf is sticky. Only Clear or reset clears it; Load does not.
- Arithmetic is unsigned; there is no signed interpretation.
- Sub is ignored when En=0.

Optional Feature:
Macro ACCUM_SATURATE_EN.
- Defined:
  - An add with c=1 sets Q to all-ones (2^W-1).
  - A subtract with b=1 sets Q to 0.
  - Cout and Ovf behave exactly as without the macro.
- Undefined: Q wraps modulo 2^W.
- Load, Clear, reset, Count and Valid are identical in both builds.

Test Plan:
1. W=8: run ops, then drive R=0 between edges with Q=0x5A, Ovf=1, Count=3 -> Q=0x00, Cout=0, Ovf=0, Valid=0, Count=0 before the next edge; they stay there while R=0.
2. Load D=0x3C, then En Sub=0 D=0x05 -> Q=0x3C then 0x41; Cout=0; Valid=1 on both cycles; Count=1 then 2.
3. Q=0xF0, En add D=0x20 -> Q=0x10 (with ACCUM_SATURATE_EN: 0xFF), Cout=1, Ovf=1. Next add D=0x01 -> Cout=0, Ovf stays 1, Q=0x11 (sat build: 0xFF, since 0xFF+0x01 overflows and Cout=1).
4. Q=0x05, En Sub=1 D=0x07 -> Q=0xFE (sat build: 0x00), Cout=1, Ovf=1. Then Sub D=0x01 from Q=0x10 -> Q=0x0F, Cout=0.
5. Clear=1, Load=1 and En=1 together with Q=0x77, Ovf=1 -> Q=0x00, Ovf=0, Count=0, Valid=1. An idle cycle after -> Valid=0, all else held.
6. CW=4: 20 consecutive En add D=0x01 from Q=0 -> Q=0x14, Count stops at 15 and holds; one Clear -> Count=0.
